// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//  - MIPS field bit ranges used to split the fetched instruction for decode
//  - default reset PC and the NOP word shown on id_instr while nothing is presented
//  - fetch FSM state type
package instr_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 26;
    localparam int unsigned RS_MSB   = 25;
    localparam int unsigned RS_LSB   = 21;
    localparam int unsigned RT_MSB   = 20;
    localparam int unsigned RT_LSB   = 16;
    localparam int unsigned RD_MSB   = 15;
    localparam int unsigned RD_LSB   = 11;
    localparam int unsigned FUNC_MSB = 5;
    localparam int unsigned FUNC_LSB = 0;
    localparam int unsigned IMM_MSB  = 15;
    localparam int unsigned IMM_LSB  = 0;

    typedef enum logic [0:0] {
        StBoot,
        StFetch
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous FIFO used by the fetch unit, both as the instruction+PC prefetch buffer
// and as the queue of issued-but-unanswered fetch addresses.
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  push/push_data  write an entry (ignored when full)
//  pop          drop the head entry (ignored when empty)
//  flush        empty the FIFO; overrides push and pop
//  head         current head entry (undefined while empty)
//  empty        no entries held
//  count        number of entries held
module instr_fetch_unit_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && (count_q != DEPTH_C);
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: readers gate the head with empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues word fetches over a valid/ready request
// channel with in-order responses, buffers returned instructions with their PCs and
// presents them to decode with the MIPS fields pre-split. A redirect flushes everything
// in flight; responses to requests issued before it are counted and discarded.
// Ports:
//  clk, rst_n                      clock, asynchronous active-low reset
//  imem_req_valid/ready, imem_addr fetch request channel
//  imem_rsp_valid, imem_rsp_data   in-order fetch response
//  redirect_valid, redirect_pc     branch/jump target load and flush
//  id_valid/ready, id_pc, id_instr instruction handed to decode
//  id_opcode/rs/rt/rd/func/imm     decode fields of id_instr
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned        ADDR_W     = 32,
    parameter int unsigned        DATA_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC   = ADDR_W'(RESET_PC_DEFAULT),
    parameter int unsigned        FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_instr,
    output logic [5:0]        id_opcode,
    output logic [4:0]        id_rs,
    output logic [4:0]        id_rt,
    output logic [4:0]        id_rd,
    output logic [5:0]        id_func,
    output logic [15:0]       id_imm
);

    localparam int unsigned      CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned      ENT_W     = ADDR_W + DATA_W;
    localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic              credit_ok, req_fire, rsp_keep, id_pop;
    logic [ADDR_W-1:0] addr_head;
    logic              addr_empty;
    logic [CNT_W-1:0]  addr_count;
    logic [ENT_W-1:0]  ifq_head;
    logic              ifq_empty;
    logic [CNT_W-1:0]  ifq_count;

    assign id_pop   = !ifq_empty && id_ready && !redirect_valid;
    assign rsp_keep = imem_rsp_valid && (drop_q == '0);

    // Requests in flight plus buffered entries may never exceed the FIFO depth, so
    // every response has a slot. A same-cycle decode pop frees a slot early, which is
    // what sustains one instruction per cycle with single-cycle memory.
    assign credit_ok = ({1'b0, outstanding_q} + {1'b0, ifq_count} - (CNT_W + 1)'(id_pop))
                       < DEPTH_LIM;

    assign imem_req_valid = (state_q == StFetch) && credit_ok && !redirect_valid;
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        drop_d        = drop_q;
        if (state_q == StBoot) state_d = StFetch;
        if (req_fire) pc_d = pc_q + ADDR_W'(4);
        if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
        if (redirect_valid) begin
            state_d = StFetch;
            pc_d    = redirect_pc & ~ADDR_W'(3);
            // Everything not yet returned after this cycle's response is stale.
            drop_d  = outstanding_q - CNT_W'(imem_rsp_valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    instr_fetch_unit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W)
    ) u_addr_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (rsp_keep),
        .flush     (redirect_valid),
        .head      (addr_head),
        .empty     (addr_empty),
        .count     (addr_count)
    );

    instr_fetch_unit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_instr_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_keep && !redirect_valid),
        .push_data ({addr_head, imem_rsp_data}),
        .pop       (id_pop),
        .flush     (redirect_valid),
        .head      (ifq_head),
        .empty     (ifq_empty),
        .count     (ifq_count)
    );

    // Data outputs read as zero whenever nothing is presented.
    assign id_valid  = !ifq_empty;
    assign id_pc     = ifq_empty ? '0 : ifq_head[ENT_W-1:DATA_W];
    assign id_instr  = ifq_empty ? DATA_W'(INSTR_NOP) : ifq_head[DATA_W-1:0];
    assign id_opcode = id_instr[OPC_MSB:OPC_LSB];
    assign id_rs     = id_instr[RS_MSB:RS_LSB];
    assign id_rt     = id_instr[RT_MSB:RT_LSB];
    assign id_rd     = id_instr[RD_MSB:RD_LSB];
    assign id_func   = id_instr[FUNC_MSB:FUNC_LSB];
    assign id_imm    = id_instr[IMM_MSB:IMM_LSB];

    rsp_needs_request: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (outstanding_q != '0));

    kept_rsp_has_addr: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_keep |-> !addr_empty);

    // Live (non-dropped) requests are exactly those with a queued address.
    addr_q_tracks_live: assert property (@(posedge clk) disable iff (!rst_n)
        addr_count == (outstanding_q - drop_q));

endmodule
